ising_run_ctrl: RTL and testbench

ISING_RUN_CTRL -- requirements
Module: ising_run_ctrl

---
 rtl/ising_pkg.sv | 19 +
 rtl/ising_run_ctrl_if.sv | 26 ++
 rtl/spin_sync.sv | 23 ++
 rtl/ising_run_ctrl.sv | 161 ++++++++++++++++
 tb/tb_ising_run_ctrl.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/ising_pkg.sv
// Shared types for the Ising run controller: FSM state encoding and the zero-coupling weight level.
// No logic; no latency.
// No flow control.
package ising_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_RUN    = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_DONE   = 3'd4
    } run_state_t;

    // The middle coupling level corresponds to zero coupling strength.
    function automatic int unsigned zero_coupling(input int unsigned num_weights);
        return num_weights / 2;
    endfunction

endpackage

// File: rtl/ising_run_ctrl_if.sv
// Weight-configuration write channel into the Ising run controller.
// No logic; no latency.
// Valid/ready: a write transfers when cfg_valid && cfg_ready.
interface ising_run_ctrl_if #(
    parameter int N           = 8,
    parameter int NUM_WEIGHTS = 5
);
    localparam int IDX_W = $clog2(N);
    localparam int WW    = $clog2(NUM_WEIGHTS);

    logic             cfg_valid;
    logic             cfg_ready;
    logic [IDX_W-1:0] cfg_row;
    logic [IDX_W-1:0] cfg_col;
    logic [WW-1:0]    cfg_weight;

    modport master (
        output cfg_valid, cfg_row, cfg_col, cfg_weight,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_row, cfg_col, cfg_weight,
        output cfg_ready
    );
endinterface

// File: rtl/spin_sync.sv
// Two-flop synchronizer bringing the asynchronous oscillator phases into the clk domain.
// Latency: 2 cycles.
// No backpressure; samples every cycle.
module spin_sync #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] meta_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '0;
            q      <= '0;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end
endmodule

// File: rtl/ising_run_ctrl.sv
// Sequences an Ising-machine run (settle, oscillate, sample) and holds the symmetric coupling weights.
// Latency: start to done = SETTLE_CYC + run_cycles + 3 cycles.
// cfg writes stall (cfg_ready=0) whenever a run is in progress; start while busy is ignored.
module ising_run_ctrl
    import ising_pkg::*;
#(
    parameter int N           = 8,
    parameter int NUM_WEIGHTS = 5,
    parameter int CNT_W       = 16,
    parameter int SETTLE_CYC  = 4,
    localparam int WW         = $clog2(NUM_WEIGHTS),
    localparam int IDX_W      = $clog2(N)
) (
    input  logic                clk,
    input  logic                rst,
    ising_run_ctrl_if.slave     cfg,
    input  logic                start,
    input  logic                abort,
    input  logic [CNT_W-1:0]    run_cycles,
    input  logic [N-1:0]        spin_in,
    output logic [N*N*WW-1:0]   weights,
    output logic                osc_en,
    output logic                busy,
    output logic                done,
    output logic                cfg_err,
    output logic [N-1:0]        spins_out
);
    localparam logic [WW-1:0]    ZERO_W      = WW'(zero_coupling(NUM_WEIGHTS));
    localparam logic [IDX_W:0]   IDX_LIM     = (IDX_W+1)'(N);
    localparam logic [WW:0]      W_LIM       = (WW+1)'(NUM_WEIGHTS);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

    run_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] run_len_q;
    logic [N-1:0]     spin_sync_q;
    logic             start_acc;
    logic             load_spins;
    logic             wr_acc;
    logic             wr_ok;

    spin_sync #(.W(N)) u_spin_sync (
        .clk (clk),
        .rst (rst),
        .d   (spin_in),
        .q   (spin_sync_q)
    );

    // Outputs decode the state register directly so reset drops osc_en without waiting for an edge.
    assign osc_en        = (state_q == ST_RUN);
    assign busy          = (state_q != ST_IDLE);
    assign done          = (state_q == ST_DONE);
    assign cfg.cfg_ready = (state_q == ST_IDLE);

    assign wr_acc = cfg.cfg_valid && cfg.cfg_ready;
    assign wr_ok  = (cfg.cfg_row != cfg.cfg_col)
                 && ({1'b0, cfg.cfg_row}    < IDX_LIM)
                 && ({1'b0, cfg.cfg_col}    < IDX_LIM)
                 && ({1'b0, cfg.cfg_weight} < W_LIM);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        start_acc  = 1'b0;
        load_spins = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_SETTLE;
                    cnt_d     = '0;
                    start_acc = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (cnt_q == run_len_q - CNT_W'(1)) begin
                    state_d = ST_SAMPLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_SAMPLE: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d    = ST_DONE;
                    cnt_d      = '0;
                    load_spins = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        if (abort && (state_q != ST_IDLE)) begin
            state_d    = ST_IDLE;
            cnt_d      = '0;
            load_spins = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            run_len_q <= CNT_W'(1);
            spins_out <= '0;
            cfg_err   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (start_acc) begin
                run_len_q <= (run_cycles == '0) ? CNT_W'(1) : run_cycles;
            end
            if (load_spins) begin
                spins_out <= spin_sync_q;
            end
            // A same-cycle bad write and start: the start acceptance clears the error.
            if (start_acc) begin
                cfg_err <= 1'b0;
            end else if (wr_acc && !wr_ok) begin
                cfg_err <= 1'b1;
            end
        end
    end

    for (genvar r = 0; r < N; r++) begin : g_row
        for (genvar c = 0; c < N; c++) begin : g_col
            localparam logic [IDX_W-1:0] R = IDX_W'(r);
            localparam logic [IDX_W-1:0] C = IDX_W'(c);
            logic [WW-1:0] cell_q;
            logic          hit;

            assign hit = wr_acc && wr_ok
                      && (((cfg.cfg_row == R) && (cfg.cfg_col == C))
                       || ((cfg.cfg_row == C) && (cfg.cfg_col == R)));

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cell_q <= ZERO_W;
                end else if (hit) begin
                    cell_q <= cfg.cfg_weight;
                end
            end

            assign weights[(r*N+c)*WW +: WW] = cell_q;
        end
    end
endmodule

// File: tb/tb_ising_run_ctrl.sv
// Directed bench for ising_run_ctrl: reset, symmetric weight writes, full run, stalled write, abort, zero length, reset mid-run.
// Inputs driven and outputs sampled 1 time unit after the rising edge.
module tb_ising_run_ctrl;
    localparam int N  = 8;
    localparam int NW = 5;
    localparam int WW = 3;

    logic              clk;
    logic              rst;
    logic              start;
    logic              abort;
    logic [15:0]       run_cycles;
    logic [N-1:0]      spin_in;
    logic [N*N*WW-1:0] weights;
    logic              osc_en;
    logic              busy;
    logic              done;
    logic              cfg_err;
    logic [N-1:0]      spins_out;

    int checks = 0;
    int errors = 0;

    logic [WW-1:0] exp_w [N][N];

    ising_run_ctrl_if #(.N(N), .NUM_WEIGHTS(NW)) cfg_if ();

    ising_run_ctrl #(
        .N(N), .NUM_WEIGHTS(NW), .CNT_W(16), .SETTLE_CYC(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg        (cfg_if.slave),
        .start      (start),
        .abort      (abort),
        .run_cycles (run_cycles),
        .spin_in    (spin_in),
        .weights    (weights),
        .osc_en     (osc_en),
        .busy       (busy),
        .done       (done),
        .cfg_err    (cfg_err),
        .spins_out  (spins_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N*N*WW-1:0] exp_flat();
        logic [N*N*WW-1:0] v;
        v = '0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                v[(r*N+c)*WW +: WW] = exp_w[r][c];
        return v;
    endfunction

    task automatic reset_model();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                exp_w[r][c] = 3'd2;
    endtask

    task automatic cfg_write(input int r, input int c, input int w);
        cfg_if.cfg_valid  = 1'b1;
        cfg_if.cfg_row    = 3'(r);
        cfg_if.cfg_col    = 3'(c);
        cfg_if.cfg_weight = 3'(w);
        tick();
        cfg_if.cfg_valid  = 1'b0;
    endtask

    initial begin
        logic done_seen;
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        run_cycles = 16'd0;
        spin_in = 8'hA5;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_row = '0;
        cfg_if.cfg_col = '0;
        cfg_if.cfg_weight = '0;
        reset_model();
        tick();
        tick();
        chk("rst_osc_en_held", osc_en, 0);
        rst = 1'b0;
        tick();

        // Reset state
        chk("rst_weights", weights, exp_flat());
        chk("rst_cfg_ready", cfg_if.cfg_ready, 1);
        chk("rst_osc_en", osc_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cfg_err", cfg_err, 0);
        chk("rst_spins_out", spins_out, 0);

        // Symmetric write, then invalid writes
        cfg_write(1, 3, 4);
        exp_w[1][3] = 3'd4;
        exp_w[3][1] = 3'd4;
        chk("wr13_weights", weights, exp_flat());
        chk("wr13_cfg_err", cfg_err, 0);
        cfg_write(2, 2, 1);
        chk("diag_weights", weights, exp_flat());
        chk("diag_cfg_err", cfg_err, 1);
        cfg_write(0, 1, 5);
        chk("wbig_weights", weights, exp_flat());
        cfg_write(0, 7, 0);
        exp_w[0][7] = 3'd0;
        exp_w[7][0] = 3'd0;
        chk("wr07_weights", weights, exp_flat());
        chk("wr07_cfg_err_sticky", cfg_err, 1);

        // Full run of 10 cycles; write held during run; start while busy ignored
        run_cycles = 16'd10;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("run1_busy", busy, 1);
        chk("run1_cfg_err_clr", cfg_err, 0);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("run1_settle_osc%0d", k), osc_en, 0);
            tick();
        end
        cfg_if.cfg_valid  = 1'b1;
        cfg_if.cfg_row    = 3'd4;
        cfg_if.cfg_col    = 3'd5;
        cfg_if.cfg_weight = 3'd3;
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("run1_run_osc%0d", k), osc_en, 1);
            chk($sformatf("run1_run_rdy%0d", k), cfg_if.cfg_ready, 0);
            start = (k == 2);
            run_cycles = (k == 2) ? 16'd3 : 16'd10;
            tick();
        end
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("run1_sample_osc%0d", k), osc_en, 0);
            chk($sformatf("run1_sample_done%0d", k), done, 0);
            chk($sformatf("run1_sample_rdy%0d", k), cfg_if.cfg_ready, 0);
            tick();
        end
        chk("run1_done", done, 1);
        chk("run1_spins_out", spins_out, 8'hA5);
        chk("run1_weights_held", weights, exp_flat());
        tick();
        chk("run1_idle_done", done, 0);
        chk("run1_idle_busy", busy, 0);
        chk("run1_idle_rdy", cfg_if.cfg_ready, 1);
        chk("stall_not_yet", weights, exp_flat());
        tick();
        cfg_if.cfg_valid = 1'b0;
        exp_w[4][5] = 3'd3;
        exp_w[5][4] = 3'd3;
        chk("stall_landed", weights, exp_flat());

        // Abort at RUN cycle 5
        spin_in = 8'h3C;
        run_cycles = 16'd20;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        for (int k = 0; k < 4; k++) tick();
        chk("abort_pre_osc", osc_en, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_osc", osc_en, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        done_seen = 1'b0;
        for (int k = 0; k < 30; k++) begin
            done_seen = done_seen | done;
            tick();
        end
        chk("abort_no_done", done_seen, 0);
        chk("abort_spins_kept", spins_out, 8'hA5);

        // run_cycles = 0 behaves as 1
        run_cycles = 16'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("zero_settle_osc%0d", k), osc_en, 0);
            tick();
        end
        chk("zero_run_osc", osc_en, 1);
        tick();
        chk("zero_after_osc", osc_en, 0);
        tick();
        tick();
        chk("zero_done", done, 1);
        chk("zero_spins_out", spins_out, 8'h3C);
        tick();

        // Reset mid-run drops osc_en without a clock edge
        run_cycles = 16'd10;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        chk("rstmid_pre_osc", osc_en, 1);
        rst = 1'b1;
        #1;
        chk("rstmid_osc", osc_en, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_spins", spins_out, 0);
        reset_model();
        chk("rstmid_weights", weights, exp_flat());
        tick();
        rst = 1'b0;
        tick();
        chk("rstmid_rdy", cfg_if.cfg_ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
